// File: rtl/tick_sched_pkg.sv
// -----------------------------------------------------------------------------
// tick_sched_pkg
// Shared types and constants for the tick_scheduler slice.
//   sched_state_t  : scan FSM state (IDLE, SCAN)
//   MODE_ONESHOT   : channel fires once, then goes inactive
//   MODE_PERIODIC  : channel reloads its period after each tick
//   DEF_*          : default parameter values for the top level
// -----------------------------------------------------------------------------
package tick_sched_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } sched_state_t;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   localparam int unsigned DEF_PRESCALE = 100000;  // 1 kHz base tick at 100 MHz
   localparam int unsigned DEF_NUM_CH   = 4;
   localparam int unsigned DEF_PERIOD_W = 16;

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Shared base-tick generator. Counts 0..PRESCALE-1 and wraps; base_tick is a
// registered one-cycle pulse in the cycle after the count reaches PRESCALE-1.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-low reset
//   base_tick  out  one-cycle pulse every PRESCALE cycles
// -----------------------------------------------------------------------------
module tick_prescaler
   import tick_sched_pkg::*;
#(
   parameter int unsigned PRESCALE = DEF_PRESCALE
) (
   input  logic clk,
   input  logic rst,
   output logic base_tick
);

   localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [CNT_W-1:0] cnt_q;
   logic             wrap;

   assign wrap = (cnt_q == CNT_W'(PRESCALE - 1));

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples its inputs from the same edge regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q     <= '0;
         base_tick <= 1'b0;
      end else begin
         base_tick <= wrap;
         cnt_q     <= wrap ? '0 : cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/tick_scheduler.sv
// -----------------------------------------------------------------------------
// tick_scheduler
// Multi-channel one-shot / periodic tick controller. One shared prescaler
// produces base ticks; on each base tick a small FSM walks the channels once,
// decrementing each active channel's remaining count with one shared
// decrementer and pulsing tick[i] when it expires.
// Optional feature macro: TICK_SCHED_RDBK_EN adds rd_ch / rd_remain readback.
// Ports:
//   clk, rst     clock, synchronous active-low reset
//   cfg_valid    config write request
//   cfg_ready    high in IDLE; writes stall during a scan
//   cfg_ch       target channel
//   cfg_start    1 = start/restart, 0 = stop (period 0 also stops)
//   cfg_mode     0 = one-shot, 1 = periodic
//   cfg_period   period in base ticks
//   base_tick    one-cycle pulse every PRESCALE cycles
//   tick         per-channel one-cycle expiry pulse
//   busy         per-channel active flag (registered)
//   rd_ch        (TICK_SCHED_RDBK_EN) channel to read back
//   rd_remain    (TICK_SCHED_RDBK_EN) remain[rd_ch], one-cycle latency
// -----------------------------------------------------------------------------
module tick_scheduler
   import tick_sched_pkg::*;
#(
   parameter  int unsigned PRESCALE = DEF_PRESCALE,  // must be >= NUM_CH+2
   parameter  int unsigned NUM_CH   = DEF_NUM_CH,
   parameter  int unsigned PERIOD_W = DEF_PERIOD_W,
   localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic                cfg_start,
   input  logic                cfg_mode,
   input  logic [PERIOD_W-1:0] cfg_period,
   output logic                base_tick,
   output logic [NUM_CH-1:0]   tick,
   output logic [NUM_CH-1:0]   busy
`ifdef TICK_SCHED_RDBK_EN
   ,
   input  logic [CH_W-1:0]     rd_ch,
   output logic [PERIOD_W-1:0] rd_remain
`endif
);

   sched_state_t        state_q, state_d;
   logic [CH_W-1:0]     idx_q, idx_d;
   logic                cfg_fire;

   logic [NUM_CH-1:0]   active_q;
   logic [NUM_CH-1:0]   mode_q;
   logic [PERIOD_W-1:0] period_q [NUM_CH];
   logic [PERIOD_W-1:0] remain_q [NUM_CH];

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk       (clk),
      .rst       (rst),
      .base_tick (base_tick)
   );

   // Writes are only accepted outside a scan, so a write and the decrementer
   // never touch channel state in the same cycle.
   assign cfg_ready = (state_q == IDLE);
   assign cfg_fire  = cfg_valid && cfg_ready;

   // ---------------- scan FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE: begin
            if (base_tick) begin
               state_d = SCAN;
               idx_d   = '0;
            end
         end
         SCAN: begin
            if (idx_q == CH_W'(NUM_CH - 1)) begin
               state_d = IDLE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + CH_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // ---------------- channel state, decrementer, outputs ----------------
   // NOTE: the channel arrays are plain registers, not RAM, and are reset so
   // that no channel can come out of reset active with a stale count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         active_q <= '0;
         mode_q   <= '0;
         tick     <= '0;
         busy     <= '0;
         for (int i = 0; i < int'(NUM_CH); i++) begin
            period_q[i] <= '0;
            remain_q[i] <= '0;
         end
      end else begin
         tick <= '0;
         busy <= active_q;

         if (cfg_fire) begin
            if (cfg_start && (cfg_period != '0)) begin
               // Restart discards any count already in flight.
               period_q[cfg_ch] <= cfg_period;
               remain_q[cfg_ch] <= cfg_period;
               mode_q[cfg_ch]   <= cfg_mode ? MODE_PERIODIC : MODE_ONESHOT;
               active_q[cfg_ch] <= 1'b1;
            end else begin
               active_q[cfg_ch] <= 1'b0;
               remain_q[cfg_ch] <= '0;
            end
         end else if ((state_q == SCAN) && active_q[idx_q]) begin
            if (remain_q[idx_q] == PERIOD_W'(1)) begin
               tick[idx_q] <= 1'b1;
               if (mode_q[idx_q] == MODE_PERIODIC) begin
                  // Reloading at expiry keeps the period drift-free.
                  remain_q[idx_q] <= period_q[idx_q];
               end else begin
                  active_q[idx_q] <= 1'b0;
               end
            end else begin
               remain_q[idx_q] <= remain_q[idx_q] - PERIOD_W'(1);
            end
         end
      end
   end

`ifdef TICK_SCHED_RDBK_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_remain <= '0;
      end else begin
         rd_remain <= remain_q[rd_ch];
      end
   end
`endif

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Multi-channel programmable timer controller built around one shared prescaler and one shared decrementer. It sits between the top-level game/display FSMs and the board clock, replacing free-running fixed-rate dividers with run-time-configurable one-shot or periodic tick channels. A single FSM walks the channels once per base tick, so the number of counters does not grow with the channel count.

## Interface
- PRESCALE, 100000: base-tick period in clk cycles (1 kHz at 100 MHz); must be >= NUM_CH+2
- NUM_CH, 4: number of tick channels
- PERIOD_W, 16: width of channel period/remaining counts
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-low
- cfg_valid  in  1  config write request
- cfg_ready  out  1  controller can accept a write this cycle
- cfg_ch  in  $clog2(NUM_CH)  target channel
- cfg_start  in  1  1 = start/restart channel, 0 = stop channel
- cfg_mode  in  1  0 = one-shot, 1 = periodic
- cfg_period  in  PERIOD_W  period in base ticks
- base_tick  out  1  one-cycle pulse every PRESCALE cycles
- tick  out  NUM_CH  per-channel one-cycle expiry pulse
- busy  out  NUM_CH  channel active

## Operation
- Prescaler counts 0..PRESCALE-1 and wraps; base_tick is registered, high for the cycle after count == PRESCALE-1.
- Per-channel state: active, mode, period[PERIOD_W], remain[PERIOD_W].
- FSM states: IDLE, SCAN. IDLE -> SCAN when base_tick is high (idx = 0). SCAN processes channel idx and increments idx; SCAN -> IDLE after idx == NUM_CH-1.
- cfg_ready = (state == IDLE). Handshake = cfg_valid && cfg_ready, applied in that cycle.
- Start write: period <= cfg_period, mode <= cfg_mode, remain <= cfg_period, active <= 1. Restart of an already active channel discards the old remaining count.
- Start write with cfg_period == 0: treated as stop.
- Stop write: active <= 0, remain <= 0, no tick emitted.
- SCAN of active channel: if remain == 1, pulse tick[idx]; periodic reloads remain <= period, one-shot clears active. Otherwise remain <= remain - 1. Inactive channels are untouched.
- Write and base_tick in the same IDLE cycle: write is applied first; that base tick counts toward the new period.
- busy = active, registered.
- Reset: prescaler 0, state IDLE, idx 0, all channel state 0, base_tick 0, tick 0, busy 0. cfg_ready reads 1 after reset; handshakes while rst is low are ignored. Reset during SCAN abandons the scan with no tick.

## Timing
- base_tick high in cycle T. SCAN covers cycles T+1..T+NUM_CH; channel i is processed in T+1+i.
- tick[i] is high for exactly cycle T+2+i (registered).
- cfg_ready is low in T+1..T+NUM_CH. Writes stall at most NUM_CH cycles.
- A started channel with period P emits its first tick on the P-th base tick at or after the accepting cycle. Periodic channels then tick every P base ticks with no drift.
- A busy fall is visible the cycle after the one-shot's tick cycle.

## Configuration
- TICK_SCHED_RDBK_EN defined: adds inputs rd_ch ($clog2(NUM_CH)) and output rd_remain (PERIOD_W). rd_remain is registered, one-cycle latency, and returns remain[rd_ch]; reset value 0.
- Not defined: these ports and their logic are absent. All other behaviour is identical.

## Structure
- Package tick_sched_pkg: FSM state enum (IDLE, SCAN), mode constants MODE_ONESHOT = 0 and MODE_PERIODIC = 1, and the default PRESCALE/NUM_CH/PERIOD_W constants.
- Sub-module tick_prescaler (PRESCALE parameter; clk, rst, base_tick) holds the shared counter. The FSM, channel register arrays and decrementer stay in tick_scheduler.

## Test plan
Bench uses PRESCALE = 10 and NUM_CH = 4.
- Reset, then idle for 50 cycles -> base_tick pulses every 10 cycles, tick = 0, busy = 0, cfg_ready = 1 outside SCAN.
- Start ch0, one-shot, period 3 -> exactly one tick[0] on the 3rd base tick, at T+2. busy[0] falls the next cycle.
- Start ch2, periodic, period 2 -> tick[2] every 20 cycles, each at T+4. Stop write -> no further ticks, busy[2] = 0.
- Assert cfg_valid during SCAN -> cfg_ready stays low for 4 cycles. Write is accepted in the first IDLE cycle with no data loss.
- Write ch1, period 1, accepted in the same cycle as base_tick -> tick[1] at T+3 of that same base tick.
- All 4 channels periodic, period 1 -> tick[0..3] staggered at T+2..T+5. Drop rst mid-SCAN -> all outputs 0 the next cycle.
